// File: rtl/imem_port_arbiter.sv
// Shares one single-port synchronous instruction memory between CPU fetch and a loader/debug port.
// Latency: grants are combinational; every granted request gets its response exactly one cycle later.
// Backpressure: requesters hold req until gnt. In BOOT only the loader is served. In RUN fetch wins
// unless the loader has been refused STARVE_MAX times in a row.
// Optional macro IMEM_WRITE_PROTECT_EN: loader writes in RUN are granted but blocked and answered with an error.

module imem_port_arbiter #(
    parameter int IDX_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic             f_err,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    input  logic             l_done,
    output logic             l_gnt,
    output logic             l_rvalid,
    output logic [31:0]      l_rdata,
    output logic             l_err,
    output logic             cpu_hold,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam int CNT_W = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    logic             f_mis;
    logic             l_mis;
    logic             l_blocked;

    // Response bookkeeping for the access granted in the previous cycle.
    logic             resp_err;
    logic             resp_zero;
    logic             resp_err_nxt;
    logic             resp_zero_nxt;
    logic [31:0]      resp_data;

    // Last delivered read data, held for each port between its responses.
    logic [31:0]      f_hold;
    logic [31:0]      l_hold;

    // Address bits above the word index are deliberately ignored (addresses wrap).
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:IDX_W+2], l_addr[31:IDX_W+2]};

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
    assign f_mis      = (f_addr[1:0] != 2'b00);
    assign l_mis      = (l_addr[1:0] != 2'b00);

`ifdef IMEM_WRITE_PROTECT_EN
    // Once the CPU runs, the program image is read-only to the loader.
    assign l_blocked = (state == RUN) && l_we;
`else
    assign l_blocked = 1'b0;
`endif

    // Pick at most one winner: loader only in BOOT, fetch-first with starvation override in RUN.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (state == BOOT) begin
                l_gnt = l_req;
            end else if (l_req && (!f_req || starve_hit)) begin
                l_gnt = 1'b1;
            end else begin
                f_gnt = f_req;
            end
        end
    end

    // Drive the memory from the winner; misaligned or blocked accesses never reach the macro.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = f_addr[IDX_W+1:2];
        mem_wdata = l_wdata;
        if (l_gnt) begin
            mem_idx = l_addr[IDX_W+1:2];
            mem_en  = !l_mis && !l_blocked;
            mem_we  = l_we && !l_mis && !l_blocked;
        end else if (f_gnt) begin
            mem_en  = !f_mis;
        end
    end

    // Classify the response that the current grant will produce next cycle.
    always_comb begin
        resp_err_nxt  = 1'b0;
        resp_zero_nxt = 1'b0;
        if (l_gnt) begin
            resp_err_nxt  = l_mis || l_blocked;
            resp_zero_nxt = l_mis || l_blocked || l_we;
        end else if (f_gnt) begin
            resp_err_nxt  = f_mis;
            resp_zero_nxt = f_mis;
        end
    end

    // Boot/run sequencing, registered cpu_hold and the loader starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            cpu_hold   <= 1'b1;
            starve_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    starve_cnt <= '0;
                    if (l_done) begin
                        state    <= RUN;
                        cpu_hold <= 1'b0;
                    end
                end
                RUN: begin
                    if (l_req && !l_gnt) begin
                        if (!starve_hit) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    // Register the owner of this cycle's grant so its response pulses exactly one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rvalid  <= 1'b0;
            l_rvalid  <= 1'b0;
            resp_err  <= 1'b0;
            resp_zero <= 1'b0;
        end else begin
            f_rvalid  <= f_gnt;
            l_rvalid  <= l_gnt;
            resp_err  <= resp_err_nxt;
            resp_zero <= resp_zero_nxt;
        end
    end

    // Memory data arrives in the response cycle; errors and writes return zero.
    assign resp_data = resp_zero ? 32'h0 : mem_rdata;

    // Capture delivered data so each port's rdata holds while the other port is served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_hold <= '0;
            l_hold <= '0;
        end else begin
            if (f_rvalid) begin
                f_hold <= resp_data;
            end
            if (l_rvalid) begin
                l_hold <= resp_data;
            end
        end
    end

    assign f_rdata = f_rvalid ? resp_data : f_hold;
    assign l_rdata = l_rvalid ? resp_data : l_hold;
    assign f_err   = f_rvalid && resp_err;
    assign l_err   = l_rvalid && resp_err;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: behavioural SRAM, rule-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_imem_port_arbiter;

    localparam int IDX_W = 8;
    localparam int SMAX  = 4;
`ifdef IMEM_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_done;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        l_err;
    logic        cpu_hold;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_idx;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    imem_port_arbiter #(.IDX_W(IDX_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .cpu_hold(cpu_hold), .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM seen by the DUT.
    logic [31:0] sram    [0:255];
    logic [31:0] ref_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_idx] <= mem_wdata;
            else        mem_rdata     <= sram[mem_idx];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state.
    bit          m_boot = 1'b1;
    int          m_starve = 0;
    bit          p_f = 1'b0, p_l = 1'b0, p_err = 1'b0;
    logic [31:0] p_dat = 32'h0;
    logic [31:0] h_f = 32'h0, h_l = 32'h0;

    // Every cycle: check responses due from last cycle's grant, then this cycle's grant and memory drive.
    always @(negedge clk) begin
        bit gf, gl, fmis, lmis, blk, e_en, e_we;
        logic [31:0] a;
        int ix;
        if (rst) begin
            m_boot = 1'b1; m_starve = 0;
            p_f = 1'b0; p_l = 1'b0; p_err = 1'b0; p_dat = 32'h0;
            h_f = 32'h0; h_l = 32'h0;
        end
        if (p_f) h_f = p_dat;
        if (p_l) h_l = p_dat;
        chk("cpu_hold", cpu_hold, m_boot);
        chk("f_rvalid", f_rvalid, p_f);
        chk("l_rvalid", l_rvalid, p_l);
        if (p_f) chk("f_err", f_err, p_err);
        if (p_l) chk("l_err", l_err, p_err);
        chk("f_rdata", f_rdata, h_f);
        chk("l_rdata", l_rdata, h_l);

        gf = 1'b0; gl = 1'b0;
        if (!rst) begin
            if (m_boot)                                   gl = l_req;
            else if (l_req && (!f_req || m_starve == SMAX)) gl = 1'b1;
            else                                          gf = f_req;
        end
        chk("f_gnt", f_gnt, gf);
        chk("l_gnt", l_gnt, gl);

        fmis = (f_addr % 4) != 0;
        lmis = (l_addr % 4) != 0;
        blk  = PROT && !m_boot && l_we;
        e_en = (gf && !fmis) || (gl && !lmis && !blk);
        e_we = gl && l_we && !lmis && !blk;
        a    = gl ? l_addr : f_addr;
        ix   = int'((a / 4) % 256);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        if (e_en) chk("mem_idx", mem_idx, ix);
        if (e_we) chk("mem_wdata", mem_wdata, l_wdata);

        p_f   = gf;
        p_l   = gl;
        p_err = gf ? fmis : (gl && (lmis || blk));
        p_dat = (p_err || (gl && l_we)) ? 32'h0 : ref_mem[ix];
        if (e_we) ref_mem[ix] = l_wdata;

        if (!rst) begin
            if (m_boot) begin
                m_starve = 0;
                if (l_done) m_boot = 1'b0;
            end else if (l_req && !gl) begin
                m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            end else begin
                m_starve = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Fetch hogs the port; loader read must win on the (SMAX+1)th cycle.
    task automatic starve(input logic [31:0] addr, input logic [31:0] exp_dat);
        int n;
        n = 0;
        f_req = 1'b1; f_addr = 32'h0;
        l_req = 1'b1; l_we = 1'b0; l_addr = addr;
        for (int i = 1; i <= 12; i++) begin
            #2;
            if (l_gnt && n == 0) n = i;
            cyc();
            if (n != 0) break;
        end
        l_req = 1'b0;
        chk("starve_grant_cycle", n, SMAX + 1);
        #2;
        chk("starve_l_rvalid", l_rvalid, 1'b1);
        chk("starve_l_rdata", l_rdata, exp_dat);
        f_req = 1'b0;
        cyc();
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        f_req = 1'b0; f_addr = 32'h0;
        l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0; l_done = 1'b0;
        #1 rst = 1'b1;
        repeat (3) cyc();
        #2;
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_f_rvalid", f_rvalid, 1'b0);
        chk("rst_l_rdata", l_rdata, 32'h0);
        chk("rst_mem_en", mem_en, 1'b0);
        cyc();
        rst = 1'b0;

        // BOOT: fetch refused, loader writes two words, l_done with the last write.
        f_req = 1'b1; f_addr = 32'h0;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h4; l_wdata = 32'hCAFE0004;
        #2;
        chk("boot_f_gnt", f_gnt, 1'b0);
        chk("boot_l_gnt", l_gnt, 1'b1);
        cyc();
        l_addr = 32'h0; l_wdata = 32'h00500093; l_done = 1'b1;
        #2;
        chk("boot_mem_we", mem_we, 1'b1);
        chk("boot_wr_rvalid", l_rvalid, 1'b1);
        chk("boot_wr_err", l_err, 1'b0);
        cyc();
        l_req = 1'b0; l_we = 1'b0; l_done = 1'b0;
        #2;
        chk("run_cpu_hold", cpu_hold, 1'b0);
        chk("run_f_gnt", f_gnt, 1'b1);
        cyc();
        f_req = 1'b0;
        #2;
        chk("first_fetch_rvalid", f_rvalid, 1'b1);
        chk("first_fetch_rdata", f_rdata, 32'h00500093);
        cyc();

        // Starvation guard, twice to show the counter restarts from zero.
        starve(32'h4, 32'hCAFE0004);
        starve(32'h0, 32'h00500093);

        // Misaligned fetch.
        f_req = 1'b1; f_addr = 32'h6;
        #2;
        chk("mis_f_gnt", f_gnt, 1'b1);
        chk("mis_mem_en", mem_en, 1'b0);
        cyc();
        f_req = 1'b0;
        #2;
        chk("mis_f_rvalid", f_rvalid, 1'b1);
        chk("mis_f_err", f_err, 1'b1);
        chk("mis_f_rdata", f_rdata, 32'h0);
        cyc();

        // Address wrap: 0x400 maps to word 0.
        f_req = 1'b1; f_addr = 32'h400;
        #2;
        chk("wrap_mem_idx", mem_idx, 32'h0);
        chk("wrap_mem_en", mem_en, 1'b1);
        cyc();
        f_req = 1'b0;
        #2;
        chk("wrap_f_rdata", f_rdata, 32'h00500093);
        chk("wrap_f_err", f_err, 1'b0);
        cyc();

        // Loader write in RUN, then read back.
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h12345678;
        #2;
        chk("runwr_l_gnt", l_gnt, 1'b1);
        cyc();
        l_req = 1'b0; l_we = 1'b0;
        #2;
        chk("runwr_l_rvalid", l_rvalid, 1'b1);
        chk("runwr_l_err", l_err, PROT);
        chk("runwr_l_rdata", l_rdata, 32'h0);
        cyc();
        l_req = 1'b1; l_addr = 32'h0;
        cyc();
        l_req = 1'b0;
        #2;
        chk("runwr_readback", l_rdata, PROT ? 32'h00500093 : 32'h12345678);
        cyc();

        // Misaligned loader read.
        l_req = 1'b1; l_addr = 32'h2;
        cyc();
        l_req = 1'b0;
        #2;
        chk("mis_l_err", l_err, 1'b1);
        chk("mis_l_rdata", l_rdata, 32'h0);
        cyc();

        // Reset while a fetch response is pending.
        f_req = 1'b1; f_addr = 32'h4;
        #2;
        chk("prerst_f_gnt", f_gnt, 1'b1);
        cyc();
        rst = 1'b1; f_req = 1'b0;
        #2;
        chk("midrst_f_rvalid", f_rvalid, 1'b0);
        chk("midrst_cpu_hold", cpu_hold, 1'b1);
        chk("midrst_f_rdata", f_rdata, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        f_req = 1'b1; f_addr = 32'h0;
        #2;
        chk("postrst_f_gnt", f_gnt, 1'b0);
        cyc();
        f_req = 1'b0;
        #2;
        chk("postrst_f_rvalid", f_rvalid, 1'b0);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
